// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the packet-aware stream demultiplexer.
package stream_demux_pkg;

    // Packet tracking: IDLE waits for a packet's first beat, PKT holds the route.
    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_t;

    // Select width for n channels; never narrower than one bit.
    function automatic int sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_demux_n.sv
// 1-to-N valid/ready stream demultiplexer with a registered output stage,
// packet-sticky routing and a saturating counter of beats sent nowhere.
//
// Handshake: a beat moves on any interface in the cycle where its valid and
// ready are both high at the rising edge; valid never waits on ready, and
// in_ready depends only on the output register and out_ready, never on in_valid.
module stream_demux_n
    import stream_demux_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int N_OUT      = 4,
    parameter int DROP_CNT_W = 8,
    localparam int SEL_W     = sel_w(N_OUT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  in_last,
    output logic [N_OUT-1:0]      out_valid,
    input  logic [N_OUT-1:0]      out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_last,
    output logic                  pkt_active,
    output logic [DROP_CNT_W-1:0] drop_count
);

    // Channel count widened by one bit so out-of-range selects compare cleanly.
    localparam logic [SEL_W:0] N_OUT_L = (SEL_W + 1)'(N_OUT);

    state_t                  state_q, state_d;
    logic [SEL_W-1:0]        route_q, route_d;
    logic [SEL_W-1:0]        route;
    logic                    route_ok;

    logic                    vld_q;
    logic [SEL_W-1:0]        dest_q;
    logic [DATA_W-1:0]       data_q;
    logic                    last_q;

    logic [N_OUT-1:0]        dest_hot;
    logic                    dest_ready;
    logic                    accept;
    logic                    drain;
    logic [DROP_CNT_W-1:0]   drop_q;

    // Decode the held destination and pick its ready; other channels' ready is ignored.
    always_comb begin
        dest_hot = '0;
        for (int k = 0; k < N_OUT; k++) begin
            dest_hot[k] = (dest_q == SEL_W'(k));
        end
        dest_ready = |(dest_hot & out_ready);
    end

    assign in_ready   = !vld_q || dest_ready;
    assign accept     = in_valid && in_ready;
    assign drain      = vld_q && dest_ready;

    // First beat of a packet routes by in_sel; later beats follow the held route.
    assign route      = (state_q == IDLE) ? in_sel : route_q;
    assign route_ok   = ({1'b0, route} < N_OUT_L);

    assign out_valid  = {N_OUT{vld_q}} & dest_hot;
    assign out_data   = data_q;
    assign out_last   = last_q;
    assign pkt_active = (state_q == PKT);
    assign drop_count = drop_q;

    // Packet FSM next state: only accepted beats move it, dropped ones included.
    always_comb begin
        state_d = state_q;
        route_d = route_q;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (!in_last) begin
                        state_d = PKT;
                        route_d = in_sel;
                    end
                end
                PKT: begin
                    if (in_last) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Packet FSM state and sticky route register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            route_q <= '0;
        end else begin
            state_q <= state_d;
            route_q <= route_d;
        end
    end

    // Output register: a routable beat loads (replacing a draining one), else drain empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            dest_q <= '0;
            data_q <= '0;
            last_q <= 1'b0;
        end else if (accept && route_ok) begin
            vld_q  <= 1'b1;
            dest_q <= route;
            data_q <= in_data;
            last_q <= in_last;
        end else if (drain) begin
            vld_q  <= 1'b0;
        end
    end

    // Count beats addressed past the last channel, sticking at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
        end else if (accept && !route_ok && (drop_q != {DROP_CNT_W{1'b1}})) begin
            drop_q <= drop_q + DROP_CNT_W'(1);
        end
    end

endmodule

// File: doc/stream_demux_n.md
# stream_demux_n

Parametrised 1-to-N stream demultiplexer: routes a valid/ready input stream to one of N_OUT output channels with a one-cycle registered output stage and backpressure per channel. Adds packet-sticky routing (select sampled on the first beat, held until `in_last`) and counted discard of beats addressed to nonexistent channels. It sits between a single producer and N consumers in the datapath, replacing the fixed-width combinational 1x4 demux where flow control and packets are required.

## Interface
- `DATA_W`, 8, payload width in bits (≥1)
- `N_OUT`, 4, number of output channels (≥2, need not be a power of two)
- `DROP_CNT_W`, 8, width of the drop counter (≥1)
- `SEL_W` (localparam), `$clog2(N_OUT)`, select width
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `in_valid`  in  1  input beat valid
- `in_ready`  out  1  input beat accepted when `in_valid && in_ready`
- `in_data`  in  DATA_W  input payload
- `in_sel`  in  SEL_W  destination channel, sampled on first beat of a packet only
- `in_last`  in  1  last beat of packet
- `out_valid`  out  N_OUT  one-hot (or zero) per-channel valid
- `out_ready`  in  N_OUT  per-channel ready
- `out_data`  out  DATA_W  payload, shared by all channels
- `out_last`  out  1  last flag, shared by all channels
- `pkt_active`  out  1  high while in PKT state
- `drop_count`  out  DROP_CNT_W  saturating count of discarded beats

## Operation
- FSM states IDLE, PKT. Reset → IDLE.
- Route for an accepted beat: IDLE → `in_sel`; PKT → `route_q`.
- IDLE, accepted beat with `in_last=0`: `route_q <= in_sel`, go PKT. With `in_last=1`: single-beat packet, stay IDLE.
- PKT, accepted beat with `in_last=1`: go IDLE. `in_sel` ignored throughout PKT.
- Output register holds `vld_q`, `dest_q`, `data_q`, `last_q`. `out_valid[k] = vld_q && dest_q==k`.
- `in_ready = !vld_q || out_ready[dest_q]` (combinational from register state and `out_ready` only; never from `in_valid`).
- Accepted beat with route < N_OUT: loads register, `vld_q<=1`. Otherwise if the register drains this cycle, `vld_q<=0`.
- Accepted beat with route ≥ N_OUT (only possible when N_OUT is not a power of two): discarded, register not loaded (drains normally), `drop_count` +1, saturating at all-ones. Packet FSM still advances, so whole packet is dropped.
- Channels other than `dest_q` ignore their `out_ready`.

## Timing
- Reset values: `in_ready=1`, `out_valid=0`, `out_data=0`, `out_last=0`, `pkt_active=0`, `drop_count=0`, `route_q=0`.
- Latency: beat accepted in cycle t is on `out_*` in cycle t+1.
- Throughput: 1 beat/cycle while destination `out_ready=1`, including back-to-back packets to different channels.
- Stall: `out_valid`, `out_data`, `out_last`, `dest_q` stable while `out_valid[k]=1 && out_ready[k]=0`.
- Simultaneous drain and load in one cycle: new beat replaces old, no bubble.
- Reset mid-packet: register and FSM cleared immediately (async); in-flight beat lost; next accepted beat treated as packet start.
- `drop_count` updates the cycle after the discarded beat's acceptance.

## Structure
- Package `stream_demux_pkg`: FSM state typedef (IDLE, PKT) and a `sel_w(n)` helper returning `$clog2(n)` with minimum 1.
- Single module; no sub-module needed. Output register may be split into `stream_demux_reg` only if reused elsewhere; not required.

## Test plan
- N_OUT=4, DATA_W=8: single-beat packets 0xA1 sel=2, 0xB2 sel=0 back-to-back, all ready → `out_valid`=4'b0100 then 4'b0001 in consecutive cycles, data 0xA1, 0xB2, no bubble.
- 3-beat packet 0x10,0x11,0x12 with sel=1, then 3, 0 on beats 2–3 → all three beats on channel 1; `pkt_active` high from cycle after beat 1 until cycle after beat 3.
- Channel 3 `out_ready=0` for 5 cycles with beat 0x55 held → `out_valid[3]` held, `in_ready=0`, data stable; release → beat consumed, next beat accepted same cycle.
- N_OUT=3: 2-beat packet sel=3 → both beats accepted, no `out_valid`, `drop_count`=2; DROP_CNT_W=2, 5 drops → `drop_count`=3.
- Assert `rst_n=0` mid-packet with `out_valid[1]=1` → outputs zero same cycle; after release, beat sel=2 `in_last=1` routes to channel 2.
- Random valid/ready on all channels, 10k beats → scoreboard per-channel order and contents match, no loss or duplication.
